// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - pipeline and memory-side signal bundle for dcache_ctrl
interface dcache_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              p1_req_i;
    logic              p1_write_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [31:0]       p1_data_i;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;

    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;

    // the cache side
    modport slave (
        input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
        output p1_data_o, p1_stall_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    // the pipeline plus memory environment
    modport master (
        output p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
        input  p1_data_o, p1_stall_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache; DCACHE_STATS_EN adds hit/miss counters
module dcache_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
`ifdef DCACHE_STATS_EN
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o,
`endif
    dcache_ctrl_if.slave bus
);
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES  = 1 << INDEX_W;
    localparam int LINE_W = 8 << OFFSET_W;
    localparam int WSEL_W = OFFSET_W - 2;
    localparam logic [OFFSET_W-1:0] ZERO_OFF = '0;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

    state_t             state;
    logic [LINES-1:0]   valid;
    logic [LINES-1:0]   dirty;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINE_W-1:0]  data_mem [LINES];
    logic [INDEX_W-1:0] miss_index;
    logic [TAG_W-1:0]   miss_tag;

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [WSEL_W-1:0]  req_word;
    logic [1:0]         unused_byte_sel;
    logic               hit;
    logic               access_state;
    logic               store_hit;
    logic               refill;
    logic [31:0]        sel_word;

    assign req_index       = bus.p1_addr_i[OFFSET_W +: INDEX_W];
    assign req_tag         = bus.p1_addr_i[ADDR_W-1 -: TAG_W];
    assign req_word        = bus.p1_addr_i[2 +: WSEL_W];
    assign unused_byte_sel = bus.p1_addr_i[1:0];

    assign hit          = bus.p1_req_i && valid[req_index] && (tag_mem[req_index] == req_tag);
    assign access_state = (state == IDLE) || (state == UPDATE);
    assign store_hit    = access_state && hit && bus.p1_write_i;
    assign refill       = (state == ALLOCATE) && bus.mem_ack_i;
    assign sel_word     = data_mem[req_index][{req_word, 5'b0} +: 32];

    assign bus.p1_data_o  = (access_state && hit && !bus.p1_write_i) ? sel_word : 32'h0;
    assign bus.p1_stall_o = ((state == IDLE) && bus.p1_req_i && !hit) ||
                            (state == WRITEBACK) || (state == ALLOCATE);

    // tag and data arrays carry no reset; valid gates every use of them
    always_ff @(posedge clk_i) begin
        if (refill) begin
            data_mem[miss_index] <= bus.mem_data_i;
            tag_mem[miss_index]  <= miss_tag;
        end else if (store_hit) begin
            data_mem[req_index][{req_word, 5'b0} +: 32] <= bus.p1_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            valid            <= '0;
            dirty            <= '0;
            miss_index       <= '0;
            miss_tag         <= '0;
            bus.mem_enable_o <= 1'b0;
            bus.mem_write_o  <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.mem_data_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (store_hit) begin
                        dirty[req_index] <= 1'b1;
                    end else if (bus.p1_req_i && !hit) begin
                        miss_index       <= req_index;
                        miss_tag         <= req_tag;
                        bus.mem_enable_o <= 1'b1;
                        if (valid[req_index] && dirty[req_index]) begin
                            state           <= WRITEBACK;
                            bus.mem_write_o <= 1'b1;
                            bus.mem_addr_o  <= {tag_mem[req_index], req_index, ZERO_OFF};
                            bus.mem_data_o  <= data_mem[req_index];
                        end else begin
                            state           <= ALLOCATE;
                            bus.mem_write_o <= 1'b0;
                            bus.mem_addr_o  <= {req_tag, req_index, ZERO_OFF};
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ack_i) begin
                        state           <= ALLOCATE;
                        bus.mem_write_o <= 1'b0;
                        bus.mem_addr_o  <= {miss_tag, miss_index, ZERO_OFF};
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ack_i) begin
                        state             <= UPDATE;
                        valid[miss_index] <= 1'b1;
                        dirty[miss_index] <= 1'b0;
                        bus.mem_enable_o  <= 1'b0;
                    end
                end
                UPDATE: begin
                    if (store_hit) begin
                        dirty[req_index] <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // each access is classified once, in its first request cycle in IDLE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else if ((state == IDLE) && bus.p1_req_i) begin
            if (hit && (hit_count_o != 32'hFFFF_FFFF)) begin
                hit_count_o <= hit_count_o + 32'd1;
            end else if (!hit && (miss_count_o != 32'hFFFF_FFFF)) begin
                miss_count_o <= miss_count_o + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - randomized self-checking bench for dcache_ctrl against a line-level cache model
module tb_dcache_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    dcache_ctrl_if bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
`ifdef DCACHE_STATS_EN
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count),
`endif
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: cache contents by line, backing store keyed by line address
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_data  [32];
    logic [255:0] mem_model [logic [31:0]];
    int           m_hits;
    int           m_misses;

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
        return l;
    endfunction

    function automatic logic [255:0] mem_read(input logic [31:0] a);
        if (!mem_model.exists(a)) mem_model[a] = rand_line();
        return mem_model[a];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.p1_req_i = 1'b0;
        bus.mem_ack_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.p1_req_i = 1'b0;
            bus.mem_ack_i = 1'b0;
            #1;
            n_cmp++;
            if (bus.p1_stall_o !== 1'b0 || bus.p1_data_o !== 32'h0 || bus.mem_enable_o !== 1'b0) begin
                n_fail++;
                $display("FAIL idle: stall=%b data=%h enable=%b required 0/0/0",
                         bus.p1_stall_o, bus.p1_data_o, bus.mem_enable_o);
            end
        end
    endtask

    // one complete pipeline access, acting as the memory with dly wait cycles before each ack
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input int dly);
        logic [4:0]   idx;
        logic [21:0]  tg;
        logic [2:0]   w;
        logic [31:0]  laddr;
        logic [31:0]  vaddr;
        logic [255:0] line;
        bit           mhit;
        idx   = addr[9:5];
        tg    = addr[31:10];
        w     = addr[4:2];
        laddr = {addr[31:5], 5'b0};
        mhit  = m_valid[idx] && (m_tag[idx] == tg);
        @(negedge clk);
        bus.p1_req_i   = 1'b1;
        bus.p1_write_i = wr;
        bus.p1_addr_i  = addr;
        bus.p1_data_i  = wdata;
        bus.mem_ack_i  = 1'b0;
        #1;
        n_cmp++;
        if (bus.p1_stall_o !== (mhit ? 1'b0 : 1'b1) || bus.mem_enable_o !== 1'b0) begin
            n_fail++;
            $display("FAIL req_cycle @%h: stall=%b enable=%b required stall=%b enable=0",
                     addr, bus.p1_stall_o, bus.mem_enable_o, !mhit);
        end
        if (mhit && !wr) begin
            n_cmp++;
            if (bus.p1_data_o !== m_data[idx][w*32 +: 32]) begin
                n_fail++;
                $display("FAIL load_hit @%h: got %h required %h", addr, bus.p1_data_o, m_data[idx][w*32 +: 32]);
            end
        end
        if (mhit) m_hits++;
        else m_misses++;
        if (!mhit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                vaddr = {m_tag[idx], idx, 5'b0};
                for (int c = 0; c <= dly; c++) begin
                    @(negedge clk);
                    bus.mem_ack_i = (c == dly);
                    #1;
                    n_cmp++;
                    if ({bus.p1_stall_o, bus.mem_enable_o, bus.mem_write_o} !== 3'b111 ||
                        bus.mem_addr_o !== vaddr || bus.mem_data_o !== m_data[idx]) begin
                        n_fail++;
                        $display("FAIL writeback cyc%0d: st/en/wr=%b addr=%h data=%h required 111 addr=%h data=%h",
                                 c, {bus.p1_stall_o, bus.mem_enable_o, bus.mem_write_o},
                                 bus.mem_addr_o, bus.mem_data_o, vaddr, m_data[idx]);
                    end
                end
                mem_model[vaddr] = m_data[idx];
            end
            line = mem_read(laddr);
            for (int c = 0; c <= dly; c++) begin
                @(negedge clk);
                bus.mem_ack_i  = (c == dly);
                bus.mem_data_i = (c == dly) ? line : rand_line();
                #1;
                n_cmp++;
                if ({bus.p1_stall_o, bus.mem_enable_o, bus.mem_write_o} !== 3'b110 ||
                    bus.mem_addr_o !== laddr) begin
                    n_fail++;
                    $display("FAIL allocate cyc%0d: st/en/wr=%b addr=%h required 110 addr=%h",
                             c, {bus.p1_stall_o, bus.mem_enable_o, bus.mem_write_o}, bus.mem_addr_o, laddr);
                end
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            m_data[idx]  = line;
            @(negedge clk);
            bus.mem_ack_i = 1'b0;
            #1;
            n_cmp++;
            if (bus.p1_stall_o !== 1'b0 || bus.mem_enable_o !== 1'b0 ||
                (!wr && bus.p1_data_o !== line[w*32 +: 32])) begin
                n_fail++;
                $display("FAIL update @%h: stall=%b enable=%b data=%h required 0 0 %h",
                         addr, bus.p1_stall_o, bus.mem_enable_o, bus.p1_data_o, wr ? 32'h0 : line[w*32 +: 32]);
            end
        end
        if (wr) begin
            m_data[idx][w*32 +: 32] = wdata;
            m_dirty[idx] = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if (bus.p1_stall_o !== 1'b0 || bus.mem_enable_o !== 1'b0 || bus.mem_write_o !== 1'b0 ||
            bus.mem_addr_o !== 32'h0 || bus.mem_data_o !== 256'h0 || bus.p1_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: stall=%b en=%b wr=%b addr=%h data_o=%h required all zero",
                     bus.p1_stall_o, bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o, bus.p1_data_o);
        end
    endtask

    task automatic test_cold_load();
        logic [255:0] l;
        l = rand_line();
        l[31:0] = 32'hDEADBEEF;
        mem_model[32'h40] = l;
        access(1'b0, 32'h0000_0040, 32'h0, 2);
    endtask

    task automatic test_store_hit();
        access(1'b1, 32'h0000_0044, 32'h1234_5678, 0);
        access(1'b0, 32'h0000_0044, 32'h0, 0);
        n_cmp++;
        if (bus.p1_data_o !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL store_readback: got %h required 12345678", bus.p1_data_o);
        end
    endtask

    task automatic test_writeback();
        access(1'b0, 32'h0000_0440, 32'h0, 1);
        access(1'b0, 32'h0000_0448, 32'h0, 0);
    endtask

    task automatic test_delayed_ack();
        access(1'b1, 32'h0000_0440, $urandom(), 0);
        access(1'b0, 32'h0000_0040, 32'h0, 10);
    endtask

    task automatic test_stray_ack();
        @(negedge clk);
        bus.p1_req_i = 1'b0;
        bus.mem_ack_i = 1'b1;
        bus.mem_data_i = rand_line();
        idle(2);
        access(1'b0, 32'h0000_0040, 32'h0, 0);
    endtask

    task automatic test_reset_mid_alloc();
        do_reset();
        @(negedge clk);
        bus.p1_req_i = 1'b1;
        bus.p1_write_i = 1'b0;
        bus.p1_addr_i = 32'h0000_0040;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.mem_enable_o !== 1'b1 || bus.mem_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_alloc: en=%b wr=%b required 1 0", bus.mem_enable_o, bus.mem_write_o);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.mem_enable_o !== 1'b0 || bus.p1_stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_alloc: en=%b stall=%b required 0 1", bus.mem_enable_o, bus.p1_stall_o);
        end
        bus.p1_req_i = 1'b0;
        m_hits = 0;
        m_misses = 0;
        access(1'b0, 32'h0000_0040, 32'h0, 1);
    endtask

    task automatic test_req_drop();
        logic [255:0] l;
        l = mem_read(32'h0000_8060);
        @(negedge clk);
        bus.p1_req_i = 1'b1;
        bus.p1_write_i = 1'b1;
        bus.p1_addr_i = 32'h0000_8064;
        bus.p1_data_i = ~l[63:32];
        #1;
        m_misses++;
        n_cmp++;
        if (bus.p1_stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_req_cycle: stall=%b required 1", bus.p1_stall_o);
        end
        @(negedge clk);
        bus.p1_req_i = 1'b0;
        #1;
        n_cmp++;
        if ({bus.p1_stall_o, bus.mem_enable_o, bus.mem_write_o} !== 3'b110) begin
            n_fail++;
            $display("FAIL drop_alloc: st/en/wr=%b required 110", {bus.p1_stall_o, bus.mem_enable_o, bus.mem_write_o});
        end
        @(negedge clk);
        bus.mem_ack_i = 1'b1;
        bus.mem_data_i = l;
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
        #1;
        n_cmp++;
        if (bus.p1_stall_o !== 1'b0 || bus.mem_enable_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_update: stall=%b en=%b required 0 0", bus.p1_stall_o, bus.mem_enable_o);
        end
        m_valid[3] = 1'b1;
        m_dirty[3] = 1'b0;
        m_tag[3] = 22'h20;
        m_data[3] = l;
        access(1'b0, 32'h0000_8064, 32'h0, 0);
        access(1'b0, 32'h0000_0060, 32'h0, 0);
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        do_reset();
        access(1'b0, 32'h0000_0100, 32'h0, 0);
        access(1'b1, 32'h0000_0104, 32'h5555_AAAA, 0);
        access(1'b0, 32'h0000_0104, 32'h0, 0);
        access(1'b0, 32'h0000_0200, 32'h0, 1);
        access(1'b0, 32'h0000_0208, 32'h0, 0);
        idle(1);
        n_cmp++;
        if (hit_count !== 32'd3 || miss_count !== 32'd2) begin
            n_fail++;
            $display("FAIL stats_3_2: hits=%0d misses=%0d required 3 2", hit_count, miss_count);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 300; i++) begin
            a = {20'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom()), 2'b00};
            access(1'($urandom()), a, $urandom(), $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(1);
`ifdef DCACHE_STATS_EN
        n_cmp++;
        if (hit_count !== 32'(m_hits) || miss_count !== 32'(m_misses)) begin
            n_fail++;
            $display("FAIL stats_random: hits=%0d misses=%0d required %0d %0d",
                     hit_count, miss_count, m_hits, m_misses);
        end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.p1_req_i = 1'b0;
        bus.p1_write_i = 1'b0;
        bus.p1_addr_i = 32'h0;
        bus.p1_data_i = 32'h0;
        bus.mem_data_i = '0;
        bus.mem_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_cold_load();
        test_store_hit();
        test_writeback();
        test_delayed_ack();
        test_stray_ack();
        test_reset_mid_alloc();
        test_req_drop();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
